// File: rtl/uart_if.sv
// rtl/uart_if.sv - UART serial lines, baud setting and byte handshake bundle
interface uart_if;
   logic [15:0] baud_div;
   logic        rx_in;
   logic        rx_latch;
   logic [7:0]  rx_data;
   logic        tx_out;
   logic        tx_latch;
   logic [7:0]  tx_data;
   logic        tx_empty;

   modport master (
      output baud_div, rx_in, tx_latch, tx_data,
      input  rx_latch, rx_data, tx_out, tx_empty
   );

   modport slave (
      input  baud_div, rx_in, tx_latch, tx_data,
      output rx_latch, rx_data, tx_out, tx_empty
   );
endinterface

// File: rtl/uart.sv
// rtl/uart.sv - 8N1 UART with independent transmitter and receiver, runtime baud divider
module uart (
   input  logic   clk,
   input  logic   reset,
   uart_if.slave  bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]  tx_state;
   logic [15:0] tx_cnt;
   logic [15:0] tx_div;
   logic [2:0]  tx_bit;
   logic [7:0]  tx_shift;
   logic        tx_line;
   logic        tx_idle;

   logic        rx_s1, rx_s2, rx_prev;
   logic [1:0]  rx_state;
   logic [15:0] rx_cnt;
   logic [15:0] rx_div;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift;
   logic [7:0]  rx_buf;
   logic        rx_pulse;

   // Divider is frozen per frame so a baud change only applies from the next start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state <= S_IDLE;
         tx_cnt   <= 16'd0;
         tx_div   <= 16'd0;
         tx_bit   <= 3'd0;
         tx_shift <= 8'd0;
         tx_line  <= 1'b1;
         tx_idle  <= 1'b1;
      end else begin
         case (tx_state)
            S_IDLE: begin
               if (bus.tx_latch) begin
                  tx_shift <= bus.tx_data;
                  tx_div   <= bus.baud_div;
                  tx_cnt   <= bus.baud_div - 16'd1;
                  tx_line  <= 1'b0;
                  tx_idle  <= 1'b0;
                  tx_state <= S_START;
               end
            end
            S_START: begin
               if (tx_cnt == 16'd0) begin
                  tx_line  <= tx_shift[0];
                  tx_bit   <= 3'd0;
                  tx_cnt   <= tx_div - 16'd1;
                  tx_state <= S_DATA;
               end else begin
                  tx_cnt <= tx_cnt - 16'd1;
               end
            end
            S_DATA: begin
               if (tx_cnt == 16'd0) begin
                  tx_cnt <= tx_div - 16'd1;
                  if (tx_bit == 3'd7) begin
                     tx_line  <= 1'b1;
                     tx_state <= S_STOP;
                  end else begin
                     tx_line  <= tx_shift[1];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     tx_bit   <= tx_bit + 3'd1;
                  end
               end else begin
                  tx_cnt <= tx_cnt - 16'd1;
               end
            end
            S_STOP: begin
               if (tx_cnt == 16'd0) begin
                  tx_idle  <= 1'b1;
                  tx_state <= S_IDLE;
               end else begin
                  tx_cnt <= tx_cnt - 16'd1;
               end
            end
            default: tx_state <= S_IDLE;
         endcase
      end
   end

   // Synchronizer and edge-history flops reset high so an idle line never looks like a start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= bus.rx_in;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state <= S_IDLE;
         rx_cnt   <= 16'd0;
         rx_div   <= 16'd0;
         rx_bit   <= 3'd0;
         rx_shift <= 8'd0;
         rx_buf   <= 8'd0;
         rx_pulse <= 1'b0;
      end else begin
         rx_pulse <= 1'b0;
         case (rx_state)
            S_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  rx_cnt   <= bus.baud_div >> 1;
                  rx_div   <= bus.baud_div;
                  rx_state <= S_START;
               end
            end
            S_START: begin
               if (rx_cnt == 16'd0) begin
                  if (rx_s2) begin
                     rx_state <= S_IDLE;
                  end else begin
                     rx_cnt   <= rx_div - 16'd1;
                     rx_bit   <= 3'd0;
                     rx_state <= S_DATA;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            S_DATA: begin
               if (rx_cnt == 16'd0) begin
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  rx_cnt   <= rx_div - 16'd1;
                  if (rx_bit == 3'd7) begin
                     rx_state <= S_STOP;
                  end else begin
                     rx_bit <= rx_bit + 3'd1;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            S_STOP: begin
               // Back to idle at mid-stop so a following start edge is not missed.
               if (rx_cnt == 16'd0) begin
                  if (rx_s2) begin
                     rx_buf   <= rx_shift;
                     rx_pulse <= 1'b1;
                  end
                  rx_state <= S_IDLE;
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            default: rx_state <= S_IDLE;
         endcase
      end
   end

   assign bus.tx_out   = tx_line;
   assign bus.tx_empty = tx_idle;
   assign bus.rx_data  = rx_buf;
   assign bus.rx_latch = rx_pulse;
endmodule

// File: tb/tb_uart.sv
// tb/tb_uart.sv - directed table-driven bench for the uart block
module tb_uart;
   logic clk = 1'b0;
   logic reset;
   logic loop_en;
   logic rx_drv;
   int   checks = 0;
   int   failures = 0;
   logic [7:0] rxq[$];

   uart_if u_if ();
   uart dut (.clk(clk), .reset(reset), .bus(u_if));

   assign u_if.rx_in = loop_en ? u_if.tx_out : rx_drv;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset && u_if.rx_latch) rxq.push_back(u_if.rx_data);
   end

   typedef struct {
      logic [7:0]  data;
      int          div;
      logic [9:0]  frame;
      int          inj;
      logic [7:0]  inj_d;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rx_at(input int idx);
      if (rxq.size() > idx) return {24'd0, rxq[idx]};
      return 32'hFFFF_FFFF;
   endfunction

   // Latch d, then observe each bit at its midpoint and the cycle tx_empty returns high.
   task automatic send_watch(input logic [7:0] d, input int div, input int inj,
                             input logic [7:0] inj_d, output logic [9:0] bits,
                             output int rise, output int refall);
      @(negedge clk);
      u_if.tx_data  = d;
      u_if.tx_latch = 1'b1;
      @(negedge clk);
      u_if.tx_latch = 1'b0;
      bits   = '0;
      rise   = -1;
      refall = 0;
      for (int c = 0; c <= 11 * div + 8; c++) begin
         if (c > 0) @(negedge clk);
         u_if.tx_latch = (c == inj);
         if (c == inj) u_if.tx_data = inj_d;
         if ((c % div) == div / 2 && c / div < 10) bits[c / div] = u_if.tx_out;
         if (rise < 0 && u_if.tx_empty) rise = c;
         else if (rise >= 0 && !u_if.tx_empty) refall = 1;
      end
      u_if.tx_latch = 1'b0;
   endtask

   task automatic drive_frame(input logic [7:0] d, input logic stop, input int div);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      for (int k = 0; k < 10; k++) begin
         rx_drv = bits[k];
         repeat (div) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   initial begin
      logic [9:0] bits;
      int rise, refall, w;
      logic [7:0] b2b[3];

      vecs[0] = '{8'hA5, 174, 10'h34A, -1, 8'h00};
      vecs[1] = '{8'h00,  16, 10'h200, -1, 8'h00};
      vecs[2] = '{8'hFF,   4, 10'h3FE, -1, 8'h00};
      vecs[3] = '{8'h55,   7, 10'h2AA, -1, 8'h00};
      vecs[4] = '{8'h12,  16, 10'h224, 40, 8'h3C};
      vecs[5] = '{8'h7E,   8, 10'h2FC, 79, 8'h99};

      reset = 1'b1;
      loop_en = 1'b1;
      rx_drv = 1'b1;
      u_if.baud_div = 16'd174;
      u_if.tx_latch = 1'b0;
      u_if.tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_tx_out",   {31'd0, u_if.tx_out},   32'd1);
      check("rst_tx_empty", {31'd0, u_if.tx_empty}, 32'd1);
      check("rst_rx_latch", {31'd0, u_if.rx_latch}, 32'd0);
      check("rst_rx_data",  {24'd0, u_if.rx_data},  32'h00);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         u_if.baud_div = vecs[i].div[15:0];
         rxq.delete();
         send_watch(vecs[i].data, vecs[i].div, vecs[i].inj, vecs[i].inj_d, bits, rise, refall);
         check($sformatf("v%0d_frame", i), {22'd0, bits}, {22'd0, vecs[i].frame});
         check($sformatf("v%0d_empty_rise", i), rise, 10 * vecs[i].div);
         check($sformatf("v%0d_no_refall", i), refall, 0);
         check($sformatf("v%0d_rx_count", i), rxq.size(), 1);
         check($sformatf("v%0d_rx_byte", i), rx_at(0), {24'd0, vecs[i].data});
      end

      // Back-to-back loopback, each latch one cycle after tx_empty rises.
      u_if.baud_div = 16'd174;
      b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55;
      rxq.delete();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         u_if.tx_data  = b2b[i];
         u_if.tx_latch = 1'b1;
         @(negedge clk);
         u_if.tx_latch = 1'b0;
         w = 0;
         while (!u_if.tx_empty && w < 12 * 174) begin
            @(negedge clk);
            w++;
         end
         check($sformatf("b2b%0d_empty", i), {31'd0, u_if.tx_empty}, 32'd1);
      end
      repeat (10) @(negedge clk);
      check("b2b_count", rxq.size(), 3);
      for (int i = 0; i < 3; i++)
         check($sformatf("b2b%0d_byte", i), rx_at(i), {24'd0, b2b[i]});

      // Framing error then a good frame.
      loop_en = 1'b0;
      rx_drv  = 1'b1;
      repeat (20) @(negedge clk);
      rxq.delete();
      drive_frame(8'h81, 1'b0, 174);
      repeat (2 * 174) @(negedge clk);
      check("ferr_count", rxq.size(), 0);
      check("ferr_rx_data", {24'd0, u_if.rx_data}, 32'h55);
      drive_frame(8'h42, 1'b1, 174);
      repeat (174) @(negedge clk);
      check("after_ferr_count", rxq.size(), 1);
      check("after_ferr_byte", rx_at(0), 32'h42);

      // Short low glitch, then proof the receiver is idle again.
      rxq.delete();
      rx_drv = 1'b0;
      repeat (40) @(negedge clk);
      rx_drv = 1'b1;
      repeat (300) @(negedge clk);
      check("glitch_count", rxq.size(), 0);
      drive_frame(8'hC3, 1'b1, 174);
      repeat (174) @(negedge clk);
      check("after_glitch_count", rxq.size(), 1);
      check("after_glitch_byte", rx_at(0), 32'hC3);

      // Reset during DATA3 of a transmission.
      loop_en = 1'b1;
      u_if.baud_div = 16'd16;
      repeat (5) @(negedge clk);
      u_if.tx_data  = 8'h5A;
      u_if.tx_latch = 1'b1;
      @(negedge clk);
      u_if.tx_latch = 1'b0;
      repeat (70) @(negedge clk);
      check("pre_rst_busy", {31'd0, u_if.tx_empty}, 32'd0);
      reset = 1'b1;
      #1;
      check("midrst_tx_out",   {31'd0, u_if.tx_out},   32'd1);
      check("midrst_tx_empty", {31'd0, u_if.tx_empty}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      check("midrst_rx_data", {24'd0, u_if.rx_data}, 32'h00);
      rxq.delete();
      repeat (3) @(negedge clk);
      send_watch(8'h7E, 16, -1, 8'h00, bits, rise, refall);
      check("postrst_frame", {22'd0, bits}, {22'd0, 10'h2FC});
      check("postrst_empty_rise", rise, 160);
      check("postrst_rx_count", rxq.size(), 1);
      check("postrst_rx_byte", rx_at(0), 32'h7E);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
REQ-001 clk  input  1  system clock; all state advances on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 baud_div  input  16  bit period in clk cycles; legal range 4..65535; sampled continuously, changes take effect at the next start bit.
REQ-004 rx_in  input  1  serial receive line; idle high; asynchronous to clk.
REQ-005 rx_latch  output  1  one-cycle pulse when a valid byte is in rx_data.
REQ-006 rx_data  output  8  last correctly received byte.
REQ-007 tx_out  output  1  serial transmit line; idle high.
REQ-008 tx_latch  input  1  one-cycle request to transmit tx_data.
REQ-009 tx_data  input  8  byte to send; sampled only on the cycle tx_latch is high.
REQ-010 tx_empty  output  1  high when the transmitter is idle and can accept a byte.

Function
REQ-011 Frame format SHALL be 8N1: one start bit (0), eight data bits LSB first, one stop bit (1); each bit lasts exactly baud_div clk cycles.
REQ-012 TX states SHALL be IDLE, START, DATA (bit index 0..7), STOP.
REQ-013 In IDLE, on a clk edge with tx_latch=1, the block SHALL capture tx_data, drive tx_out=0, clear tx_empty on that same edge, and enter START.
REQ-014 The block SHALL drive each TX bit for baud_div cycles, then advance START -> DATA0..DATA7 -> STOP.
REQ-015 At the end of STOP, the block SHALL return to IDLE and set tx_empty=1 (rising edge), exactly 10*baud_div cycles after the latching edge.
REQ-016 tx_latch while tx_empty=0 SHALL be ignored; the in-flight byte completes unchanged.
REQ-017 tx_latch on the same edge tx_empty rises SHALL be ignored; a new byte is accepted from the following cycle.
REQ-018 rx_in SHALL pass through a 2-flop synchronizer before use; all RX timing is relative to the synchronized signal.
REQ-019 RX states SHALL be IDLE, START, DATA, STOP.
REQ-020 In IDLE, a synchronized 1->0 transition SHALL start the receiver and load a half-period counter of baud_div/2 (truncating).
REQ-021 At mid-start-bit, if the line is high, the block SHALL treat the start as a glitch and return to IDLE without a pulse.
REQ-022 The block SHALL sample data bits at baud_div-cycle intervals after mid-start and shift them in LSB first.
REQ-023 If the stop-bit sample is 1, the block SHALL update rx_data and assert rx_latch for exactly one cycle on the same edge.
REQ-024 If the stop-bit sample is 0 (framing error), the block SHALL discard the byte; rx_data stays unchanged and rx_latch is not asserted.
REQ-025 After the stop sample, RX SHALL return to IDLE immediately (mid-stop-bit) so that back-to-back frames are received.
REQ-026 RX and TX SHALL be fully independent; simultaneous TX and RX activity is legal.

Reset
REQ-027 While reset=1, outputs SHALL be: tx_out=1, tx_empty=1, rx_latch=0, rx_data=8'h00; both state machines SHALL be in IDLE and all counters cleared.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; after release, the next tx_latch starts a fresh frame and RX waits for a new falling edge.

Verification
REQ-029 Loopback (tx_out->rx_in), baud_div=174, send 0xA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each 174 cycles; rx_latch pulses once with rx_data=0xA5; tx_empty rises 1740 cycles after latch.
REQ-030 Loopback, send 0x00, 0xFF, 0x55 back-to-back, each issued one cycle after tx_empty rises -> three rx_latch pulses with rx_data equal to 0x00, 0xFF, 0x55 in order.
REQ-031 Pulse tx_latch with 0x3C while busy sending 0x12 -> only 0x12 is transmitted; tx_empty does not deassert again.
REQ-032 Drive rx_in with start bit, 0x81, then stop=0 -> no rx_latch; rx_data keeps its prior value; a subsequent good frame 0x42 is received.
REQ-033 Drive rx_in low for 40 cycles (baud_div=174) -> no rx_latch; receiver back in IDLE.
REQ-034 Assert reset during DATA3 of a transmission -> tx_out=1 and tx_empty=1 immediately; a new latch of 0x7E transmits correctly.
